// File: rtl/riscv_v_pkg.sv
// Shared vector-unit types and constants.
// Element width, reduction op encoding and register-sized data types.
package riscv_v_pkg;

    localparam int RISCV_V_VLEN      = 128;
    localparam int RISCV_V_ELEN      = 32;
    localparam int RISCV_V_MAX_ELEMS = RISCV_V_VLEN / 8;

    typedef logic [RISCV_V_VLEN-1:0]      riscv_v_data_t;
    typedef logic [RISCV_V_MAX_ELEMS-1:0] riscv_v_mask_t;

    typedef enum logic [1:0] {
        SEW8  = 2'd0,
        SEW16 = 2'd1,
        SEW32 = 2'd2
    } riscv_v_sew_e;

    typedef enum logic [2:0] {
        ADD = 3'd0,
        AND = 3'd1,
        OR  = 3'd2,
        XOR = 3'd3,
        MAX = 3'd4,
        MIN = 3'd5
    } riscv_v_reduct_op_e;

endpackage

// File: rtl/riscv_v_reduct_alu.sv
// Reduction datapath: folds one element into the accumulator.
// All results are truncated to the active element width.
module riscv_v_reduct_alu
    import riscv_v_pkg::*;
(
    input  logic [RISCV_V_ELEN-1:0] acc,
    input  logic [RISCV_V_ELEN-1:0] elem,
    input  riscv_v_sew_e            sew,
    input  riscv_v_reduct_op_e      op,
    input  logic                    is_signed,
    output logic [RISCV_V_ELEN-1:0] acc_nxt
);

    logic [RISCV_V_ELEN-1:0] sew_mask;
    logic [RISCV_V_ELEN:0]   acc_ext;
    logic [RISCV_V_ELEN:0]   elem_ext;
    logic                    elem_gt;
    logic [RISCV_V_ELEN-1:0] res;

    // Extend an operand from SEW to ELEN+1 so one comparator serves all widths.
    function automatic logic [RISCV_V_ELEN:0] ext(
        input logic [RISCV_V_ELEN-1:0] v,
        input riscv_v_sew_e            s,
        input logic                    sgn
    );
        logic [RISCV_V_ELEN:0] r;
        unique case (s)
            SEW8:    r = {{25{sgn & v[7]}}, v[7:0]};
            SEW16:   r = {{17{sgn & v[15]}}, v[15:0]};
            default: r = {sgn & v[31], v};
        endcase
        return r;
    endfunction

    // Operand extension, compare and op select, masked back to SEW.
    always_comb begin
        unique case (sew)
            SEW8:    sew_mask = 32'h0000_00FF;
            SEW16:   sew_mask = 32'h0000_FFFF;
            default: sew_mask = 32'hFFFF_FFFF;
        endcase
        acc_ext  = ext(acc, sew, is_signed);
        elem_ext = ext(elem, sew, is_signed);
        elem_gt  = $signed(elem_ext) > $signed(acc_ext);
        unique case (op)
            AND:     res = acc & elem;
            OR:      res = acc | elem;
            XOR:     res = acc ^ elem;
            MAX:     res = elem_gt ? elem : acc;
            MIN:     res = elem_gt ? acc : elem;
            default: res = acc + elem;
        endcase
        acc_nxt = res & sew_mask;
    end

endmodule

// File: rtl/riscv_v_reduct_seq.sv
// Vector reduction sequencer: one element per cycle into a seed.
// Stalls decode while busy and writes element 0 of vd on completion.
module riscv_v_reduct_seq
    import riscv_v_pkg::*;
#(
    parameter int VLEN = RISCV_V_VLEN,
    parameter int ELEN = RISCV_V_ELEN,
    parameter int VL_W = $clog2(VLEN/8) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_pipe,
    input  logic              start_exe,
    input  logic [VLEN-1:0]   srca_exe,
    input  logic [VLEN-1:0]   srcb_exe,
    input  logic [VLEN/8-1:0] mask_exe,
    input  logic              masked_exe,
    input  logic [1:0]        vsew_exe,
    input  logic [VL_W-1:0]   vl_exe,
    input  logic              is_add_exe,
    input  logic              is_and_exe,
    input  logic              is_or_exe,
    input  logic              is_xor_exe,
    input  logic              is_max_exe,
    input  logic              is_min_exe,
    input  logic              is_signed_exe,
    output logic              busy,
    output logic [VLEN-1:0]   result_data,
    output logic [VLEN/8-1:0] result_be,
    output logic              result_valid
);

    localparam int IDX_W = $clog2(VLEN/8);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e             state, state_nxt;
    logic [ELEN-1:0]    acc_q;
    logic [IDX_W-1:0]   idx_q;
    riscv_v_data_t      srcb_q;
    riscv_v_mask_t      mask_q;
    logic               masked_q;
    riscv_v_sew_e       sew_q;
    logic [VL_W-1:0]    vl_q;
    riscv_v_reduct_op_e op_q;
    logic               sgn_q;

    riscv_v_sew_e       sew_in;
    riscv_v_reduct_op_e op_in;
    logic [VL_W-1:0]    vl_lim;
    logic [VL_W-1:0]    vl_in;
    logic [ELEN-1:0]    seed;
    logic               accept;
    logic [ELEN-1:0]    elem;
    logic [ELEN-1:0]    alu_res;
    logic               elem_act;
    logic               last;
    logic               unused_ok;

    assign unused_ok = ^srca_exe[VLEN-1:ELEN];

    // Decode the issue bundle: width, op, clamped vl and SEW-wide seed.
    always_comb begin
        unique case (vsew_exe)
            2'b00:   sew_in = SEW8;
            2'b01:   sew_in = SEW16;
            default: sew_in = SEW32;
        endcase
        unique case (1'b1)
            is_and_exe: op_in = AND;
            is_or_exe:  op_in = OR;
            is_xor_exe: op_in = XOR;
            is_max_exe: op_in = MAX;
            is_min_exe: op_in = MIN;
            default:    op_in = ADD;
        endcase
        unique case (sew_in)
            SEW8: begin
                vl_lim = VL_W'(VLEN/8);
                seed   = ELEN'(srca_exe[7:0]);
            end
            SEW16: begin
                vl_lim = VL_W'(VLEN/16);
                seed   = ELEN'(srca_exe[15:0]);
            end
            default: begin
                vl_lim = VL_W'(VLEN/32);
                seed   = srca_exe[ELEN-1:0];
            end
        endcase
        vl_in  = (vl_exe > vl_lim) ? vl_lim : vl_exe;
        accept = (state == IDLE) && start_exe && !clear_pipe;
    end

    // Select the current element and decide whether it participates.
    always_comb begin
        unique case (sew_q)
            SEW8:    elem = ELEN'(srcb_q[{idx_q, 3'b000} +: 8]);
            SEW16:   elem = ELEN'(srcb_q[{idx_q[IDX_W-2:0], 4'b0000} +: 16]);
            default: elem = srcb_q[{idx_q[IDX_W-3:0], 5'b00000} +: 32];
        endcase
        elem_act = !masked_q || mask_q[idx_q];
        last     = (VL_W'(idx_q) == vl_q - VL_W'(1));
    end

    riscv_v_reduct_alu u_alu (
        .acc       (acc_q),
        .elem      (elem),
        .sew       (sew_q),
        .op        (op_q),
        .is_signed (sgn_q),
        .acc_nxt   (alu_res)
    );

    // State, accumulator, element index and captured operands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            acc_q    <= '0;
            idx_q    <= '0;
            srcb_q   <= '0;
            mask_q   <= '0;
            masked_q <= 1'b0;
            sew_q    <= SEW8;
            vl_q     <= '0;
            op_q     <= ADD;
            sgn_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                acc_q    <= seed;
                idx_q    <= '0;
                srcb_q   <= srcb_exe;
                mask_q   <= mask_exe;
                masked_q <= masked_exe;
                sew_q    <= sew_in;
                vl_q     <= vl_in;
                op_q     <= op_in;
                sgn_q    <= is_signed_exe;
            end else if (state == ACCUM) begin
                if (elem_act) begin
                    acc_q <= alu_res;
                end
                idx_q <= idx_q + 1'b1;
            end
        end
    end

    // Next state, stall request and writeback; a flush wins over everything.
    always_comb begin
        state_nxt    = state;
        busy         = 1'b0;
        result_valid = 1'b0;
        result_data  = '0;
        result_be    = '0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (vl_in == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                busy = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy         = 1'b1;
                result_valid = 1'b1;
                result_data  = VLEN'(acc_q);
                unique case (sew_q)
                    SEW8:    result_be = (VLEN/8)'(4'h1);
                    SEW16:   result_be = (VLEN/8)'(4'h3);
                    default: result_be = (VLEN/8)'(4'hF);
                endcase
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (clear_pipe) begin
            state_nxt    = IDLE;
            result_valid = 1'b0;
            result_data  = '0;
            result_be    = '0;
        end
    end

endmodule

// File: tb/tb_riscv_v_reduct_seq.sv
// Directed bench for the vector reduction sequencer.
// Cycle 0 is the issue cycle; checks are taken 1 time unit after each edge.
module tb_riscv_v_reduct_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic         clear_pipe;
    logic         start_exe;
    logic [127:0] srca_exe;
    logic [127:0] srcb_exe;
    logic [15:0]  mask_exe;
    logic         masked_exe;
    logic [1:0]   vsew_exe;
    logic [4:0]   vl_exe;
    logic         is_add_exe, is_and_exe, is_or_exe;
    logic         is_xor_exe, is_max_exe, is_min_exe;
    logic         is_signed_exe;
    logic         busy;
    logic [127:0] result_data;
    logic [15:0]  result_be;
    logic         result_valid;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    riscv_v_reduct_seq dut (
        .clk           (clk),
        .rst           (rst),
        .clear_pipe    (clear_pipe),
        .start_exe     (start_exe),
        .srca_exe      (srca_exe),
        .srcb_exe      (srcb_exe),
        .mask_exe      (mask_exe),
        .masked_exe    (masked_exe),
        .vsew_exe      (vsew_exe),
        .vl_exe        (vl_exe),
        .is_add_exe    (is_add_exe),
        .is_and_exe    (is_and_exe),
        .is_or_exe     (is_or_exe),
        .is_xor_exe    (is_xor_exe),
        .is_max_exe    (is_max_exe),
        .is_min_exe    (is_min_exe),
        .is_signed_exe (is_signed_exe),
        .busy          (busy),
        .result_data   (result_data),
        .result_be     (result_be),
        .result_valid  (result_valid)
    );

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int op);
        is_add_exe = (op == 0);
        is_and_exe = (op == 1);
        is_or_exe  = (op == 2);
        is_xor_exe = (op == 3);
        is_max_exe = (op == 4);
        is_min_exe = (op == 5);
    endtask

    task automatic load(input logic [1:0] sew, input logic [4:0] vl,
                        input logic [127:0] a, input logic [127:0] b,
                        input logic [15:0] m, input logic mk,
                        input int op, input logic sg);
        vsew_exe      = sew;
        vl_exe        = vl;
        srca_exe      = a;
        srcb_exe      = b;
        mask_exe      = m;
        masked_exe    = mk;
        is_signed_exe = sg;
        set_op(op);
    endtask

    // Issue in the current cycle; returns 1 unit into cycle 1.
    task automatic issue(input logic [1:0] sew, input logic [4:0] vl,
                         input logic [127:0] a, input logic [127:0] b,
                         input logic [15:0] m, input logic mk,
                         input int op, input logic sg);
        load(sew, vl, a, b, m, mk, op, sg);
        start_exe = 1'b1;
        step();
        start_exe = 1'b0;
    endtask

    // From cycle 1: busy held, valid only at cycle lat, idle afterwards.
    task automatic expect_done(input string tag, input int lat,
                               input logic [127:0] data,
                               input logic [15:0] be);
        for (int c = 1; c < lat; c++) begin
            chk({tag, " busy"}, 128'(busy), 128'(1'b1));
            chk({tag, " early_valid"}, 128'(result_valid), 128'(1'b0));
            step();
        end
        chk({tag, " valid"}, 128'(result_valid), 128'(1'b1));
        chk({tag, " busy_done"}, 128'(busy), 128'(1'b1));
        chk({tag, " data"}, result_data, data);
        chk({tag, " be"}, 128'(result_be), 128'(be));
        step();
        chk({tag, " valid_after"}, 128'(result_valid), 128'(1'b0));
        chk({tag, " busy_after"}, 128'(busy), 128'(1'b0));
    endtask

    initial begin
        rst        = 1'b1;
        clear_pipe = 1'b0;
        start_exe  = 1'b0;
        load(2'b00, 5'd0, '0, '0, '0, 1'b0, 0, 1'b0);
        step();
        chk("rst busy", 128'(busy), 128'(1'b0));
        chk("rst valid", 128'(result_valid), 128'(1'b0));
        chk("rst data", result_data, 128'h0);
        chk("rst be", 128'(result_be), 128'h0);
        rst = 1'b0;
        step();

        issue(2'b10, 5'd4, 128'd10, {32'd4, 32'd3, 32'd2, 32'd1},
              16'h0, 1'b0, 0, 1'b0);
        expect_done("sum32", 5, 128'd20, 16'h000F);

        issue(2'b00, 5'd3, 128'h80, 128'h00FE017F, 16'h0, 1'b0, 4, 1'b1);
        expect_done("smax8", 4, 128'h7F, 16'h0001);

        issue(2'b00, 5'd3, 128'h80, 128'h00FE017F, 16'h0, 1'b0, 4, 1'b0);
        expect_done("umax8", 4, 128'hFE, 16'h0001);

        issue(2'b01, 5'd4, 128'hFFFF, 128'h8000_1234_0F0F_00F0,
              16'b0101, 1'b1, 1, 1'b0);
        expect_done("and16m", 5, 128'h0030, 16'h0003);

        issue(2'b10, 5'd0, 128'hDEADBEEF, 128'h1234, 16'h0, 1'b0, 0, 1'b0);
        expect_done("vl0", 1, 128'hDEADBEEF, 16'h000F);

        issue(2'b10, 5'd4, 128'hDEADBEEF, {32'd4, 32'd3, 32'd2, 32'd1},
              16'h0, 1'b1, 0, 1'b0);
        expect_done("allmasked", 5, 128'hDEADBEEF, 16'h000F);

        issue(2'b00, 5'd3, 128'h05, 128'h00FE0109, 16'h0, 1'b0, 5, 1'b1);
        expect_done("smin8", 4, 128'hFE, 16'h0001);

        issue(2'b10, 5'd8, 128'd0, {32'd4, 32'd3, 32'd2, 32'd1},
              16'h0, 1'b0, 0, 1'b0);
        chk("flush busy c1", 128'(busy), 128'(1'b1));
        step();
        step();
        clear_pipe = 1'b1;
        start_exe  = 1'b1;
        load(2'b00, 5'd1, 128'h11, 128'h22, 16'h0, 1'b0, 0, 1'b0);
        #1;
        chk("flush valid c3", 128'(result_valid), 128'(1'b0));
        step();
        clear_pipe = 1'b0;
        start_exe  = 1'b0;
        chk("flush busy c4", 128'(busy), 128'(1'b0));
        chk("flush valid c4", 128'(result_valid), 128'(1'b0));
        step();
        chk("flush ignored busy", 128'(busy), 128'(1'b0));
        chk("flush ignored valid", 128'(result_valid), 128'(1'b0));

        issue(2'b10, 5'd8, 128'd0, {32'd4, 32'd3, 32'd2, 32'd1},
              16'h0, 1'b0, 0, 1'b0);
        expect_done("clamp32", 5, 128'd10, 16'h000F);

        issue(2'b10, 5'd0, 128'h55, 128'h0, 16'h0, 1'b0, 0, 1'b0);
        clear_pipe = 1'b1;
        #1;
        chk("flush done valid", 128'(result_valid), 128'(1'b0));
        step();
        clear_pipe = 1'b0;
        chk("flush done busy", 128'(busy), 128'(1'b0));
        chk("flush done next", 128'(result_valid), 128'(1'b0));

        issue(2'b00, 5'd2, 128'h0, 128'hF00F, 16'h0, 1'b0, 3, 1'b0);
        expect_done("xor8 a", 3, 128'hFF, 16'h0001);
        issue(2'b00, 5'd2, 128'h0, 128'h55AA, 16'h0, 1'b0, 3, 1'b0);
        expect_done("xor8 b", 3, 128'hFF, 16'h0001);

        issue(2'b00, 5'd2, 128'h0, 128'hF00F, 16'h0, 1'b0, 2, 1'b0);
        rst = 1'b1;
        #1;
        chk("rst accum busy", 128'(busy), 128'(1'b0));
        chk("rst accum valid", 128'(result_valid), 128'(1'b0));
        step();
        rst = 1'b0;
        issue(2'b10, 5'd0, 128'hCAFE, 128'h0, 16'h0, 1'b0, 0, 1'b0);
        chk("pre-rst valid", 128'(result_valid), 128'(1'b1));
        rst = 1'b1;
        #1;
        chk("rst done busy", 128'(busy), 128'(1'b0));
        chk("rst done valid", 128'(result_valid), 128'(1'b0));
        chk("rst done data", result_data, 128'h0);
        chk("rst done be", 128'(result_be), 128'h0);
        step();
        rst = 1'b0;
        step();

        issue(2'b00, 5'd2, 128'h01, 128'h4020, 16'h0, 1'b0, 2, 1'b0);
        expect_done("or8 post-rst", 3, 128'h61, 16'h0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
